// File: rtl/tetris_pkg.sv
// Shared types and gravity timing for the tetris tick scheduler.
package tetris_pkg;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_LEFT,
        ACT_RIGHT,
        ACT_DOWN,
        ACT_ROTATE,
        ACT_DROP
    } action_t;

    localparam int GRAVITY_BASE = 30;
    localparam int GRAVITY_STEP = 2;
    localparam int GRAVITY_MIN  = 2;

    // Ticks between gravity drops at a given level, floored at GRAVITY_MIN.
    function automatic logic [4:0] gravity_period(input logic [3:0] level);
        int p;
        p = GRAVITY_BASE - GRAVITY_STEP * int'(level);
        if (p < GRAVITY_MIN) p = GRAVITY_MIN;
        return p[4:0];
    endfunction

endpackage

// File: rtl/tetris_key_repeat.sv
// One key: rising-edge latch plus DAS/ARR hold counter producing a per-tick request.
module tetris_key_repeat #(
    parameter int DAS_TICKS = 10,
    parameter int ARR_TICKS = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic tick,
    input  logic consume,
    input  logic flush,
    output logic req
);
    localparam int HOLD_MAX = DAS_TICKS + ARR_TICKS - 1;
    localparam int HW       = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);

    logic          raw_q;
    logic          pending;
    logic [HW-1:0] hold;
    logic          rise;

    assign rise = raw & ~raw_q;

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            raw_q   <= 1'b0;
            pending <= 1'b0;
            hold    <= '0;
        end else begin
            raw_q <= raw;
            if (flush)        pending <= 1'b0;
            else if (rise)    pending <= 1'b1;
            else if (consume) pending <= 1'b0;
            // Past DAS the counter cycles through the ARR window instead of growing.
            if (flush || !raw) hold <= '0;
            else if (tick)     hold <= (hold == HW'(HOLD_MAX)) ? HW'(DAS_TICKS) : hold + HW'(1);
        end
    end

    assign req = pending | (raw && hold == HW'(DAS_TICKS));

endmodule

// File: rtl/tetris_tick_scheduler.sv
// Tick prescaler, key arbiter, gravity injector and line/level accumulator for tetris_game.
// Optional pause key and state are built when TETRIS_PAUSE_EN is defined.
module tetris_tick_scheduler
    import tetris_pkg::*;
#(
    parameter int CLK_HZ          = 100_000_000,
    parameter int TICK_HZ         = 60,
    parameter int DAS_TICKS       = 10,
    parameter int ARR_TICKS       = 2,
    parameter int LINES_PER_LEVEL = 10,
    parameter int MAX_LEVEL       = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_left_raw,
    input  logic        key_right_raw,
    input  logic        key_down_raw,
    input  logic        key_rotate_raw,
    input  logic        key_drop_raw,
    input  logic        line_clear_valid,
    input  logic [2:0]  line_clear_count,
    input  logic        game_over,
    output logic        tick_game,
    output logic        key_left,
    output logic        key_right,
    output logic        key_down,
    output logic        key_rotate,
    output logic        key_drop,
    output logic [3:0]  level,
    output logic [15:0] lines_total
`ifdef TETRIS_PAUSE_EN
    ,
    input  logic        key_pause_raw,
    output logic        paused
`endif
);
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int CW       = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);

    logic [CW-1:0] cnt;
    logic          run;
    logic          tick_adv;
    logic          fire;
    logic          flush;

`ifdef TETRIS_PAUSE_EN
    logic pause_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            pause_q <= 1'b0;
            paused  <= 1'b0;
        end else begin
            pause_q <= key_pause_raw;
            if (key_pause_raw && !pause_q) paused <= ~paused;
        end
    end
    assign run = ~paused;
`else
    assign run = 1'b1;
`endif

    // Decisions are taken on the edge entering the tick cycle so they land with tick_game.
    assign tick_adv = run && (cnt == CW'(TICK_DIV - 2));
    assign fire     = tick_adv & ~game_over;
    assign flush    = game_over | ~run;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            tick_game <= 1'b0;
        end else if (run) begin
            cnt       <= (cnt == CW'(TICK_DIV - 1)) ? '0 : cnt + CW'(1);
            tick_game <= tick_adv;
        end else begin
            tick_game <= 1'b0;
        end
    end

    logic    req_left, req_right, req_down;
    logic    rot_q, drop_q, pend_rotate, pend_drop;
    action_t winner;
    logic    lr_conflict;

    tetris_key_repeat #(.DAS_TICKS(DAS_TICKS), .ARR_TICKS(ARR_TICKS)) u_left (
        .clk(clk), .rst(rst), .raw(key_left_raw), .tick(tick_adv),
        .consume(fire && (winner == ACT_LEFT || lr_conflict)), .flush(flush), .req(req_left)
    );
    tetris_key_repeat #(.DAS_TICKS(DAS_TICKS), .ARR_TICKS(ARR_TICKS)) u_right (
        .clk(clk), .rst(rst), .raw(key_right_raw), .tick(tick_adv),
        .consume(fire && (winner == ACT_RIGHT || lr_conflict)), .flush(flush), .req(req_right)
    );
    tetris_key_repeat #(.DAS_TICKS(DAS_TICKS), .ARR_TICKS(ARR_TICKS)) u_down (
        .clk(clk), .rst(rst), .raw(key_down_raw), .tick(tick_adv),
        .consume(fire && winner == ACT_DOWN), .flush(flush), .req(req_down)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rot_q       <= 1'b0;
            drop_q      <= 1'b0;
            pend_rotate <= 1'b0;
            pend_drop   <= 1'b0;
        end else begin
            rot_q  <= key_rotate_raw;
            drop_q <= key_drop_raw;
            if (flush)                             pend_rotate <= 1'b0;
            else if (key_rotate_raw && !rot_q)     pend_rotate <= 1'b1;
            else if (fire && winner == ACT_ROTATE) pend_rotate <= 1'b0;
            if (flush)                             pend_drop <= 1'b0;
            else if (key_drop_raw && !drop_q)      pend_drop <= 1'b1;
            else if (fire && winner == ACT_DROP)   pend_drop <= 1'b0;
        end
    end

    // NOTE: defaults first so no path through the block leaves a latch.
    always_comb begin
        winner      = ACT_NONE;
        lr_conflict = 1'b0;
        if (pend_drop)                   winner = ACT_DROP;
        else if (pend_rotate)            winner = ACT_ROTATE;
        else if (req_down)               winner = ACT_DOWN;
        else if (req_left && req_right)  lr_conflict = 1'b1;
        else if (req_left)               winner = ACT_LEFT;
        else if (req_right)              winner = ACT_RIGHT;
    end

    logic [4:0] grav_cnt, grav_inc, period;
    logic       grav_due;

    assign period   = gravity_period(level);
    assign grav_inc = grav_cnt + 5'd1;
    assign grav_due = grav_inc >= period;

    always_ff @(posedge clk) begin
        if (rst) begin
            grav_cnt <= '0;
        end else if (fire) begin
            if (winner == ACT_DOWN) grav_cnt <= '0;
            else if (grav_due)      grav_cnt <= (winner == ACT_NONE) ? 5'd0 : period;
            else                    grav_cnt <= grav_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_left   <= 1'b0;
            key_right  <= 1'b0;
            key_down   <= 1'b0;
            key_rotate <= 1'b0;
            key_drop   <= 1'b0;
        end else begin
            key_left   <= fire && winner == ACT_LEFT;
            key_right  <= fire && winner == ACT_RIGHT;
            key_down   <= fire && (winner == ACT_DOWN || (winner == ACT_NONE && grav_due));
            key_rotate <= fire && winner == ACT_ROTATE;
            key_drop   <= fire && winner == ACT_DROP;
        end
    end

    logic [16:0] lines_sum;
    logic [15:0] lvl_raw;

    assign lines_sum = {1'b0, lines_total} + {14'd0, line_clear_count};
    assign lvl_raw   = lines_total / 16'(LINES_PER_LEVEL);

    always_ff @(posedge clk) begin
        if (rst) begin
            lines_total <= '0;
            level       <= '0;
        end else begin
            if (line_clear_valid) lines_total <= lines_sum[16] ? 16'hFFFF : lines_sum[15:0];
            level <= (lvl_raw > 16'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : lvl_raw[3:0];
        end
    end

endmodule

// File: tb/tb_tetris_tick_scheduler.sv
// Self-checking bench for tetris_tick_scheduler: tick-level behavioural model plus directed scenarios.
module tb_tetris_tick_scheduler;

    localparam int TDIV = 10;
    localparam int DAS  = 3;
    localparam int ARR  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_left_raw = 1'b0, key_right_raw = 1'b0, key_down_raw = 1'b0;
    logic        key_rotate_raw = 1'b0, key_drop_raw = 1'b0;
    logic        line_clear_valid = 1'b0;
    logic [2:0]  line_clear_count = 3'd0;
    logic        game_over = 1'b0;
    logic        tick_game, key_left, key_right, key_down, key_rotate, key_drop;
    logic [3:0]  level;
    logic [15:0] lines_total;

    tetris_tick_scheduler #(
        .CLK_HZ(1000), .TICK_HZ(100), .DAS_TICKS(DAS), .ARR_TICKS(ARR),
        .LINES_PER_LEVEL(10), .MAX_LEVEL(15)
    ) dut (
        .clk(clk), .rst(rst),
        .key_left_raw(key_left_raw), .key_right_raw(key_right_raw), .key_down_raw(key_down_raw),
        .key_rotate_raw(key_rotate_raw), .key_drop_raw(key_drop_raw),
        .line_clear_valid(line_clear_valid), .line_clear_count(line_clear_count),
        .game_over(game_over),
        .tick_game(tick_game), .key_left(key_left), .key_right(key_right), .key_down(key_down),
        .key_rotate(key_rotate), .key_drop(key_drop), .level(level), .lines_total(lines_total)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: keys indexed 0 left, 1 right, 2 down, 3 rotate, 4 drop.
    bit       model_valid = 1'b0;
    int       m_n, m_grav, m_lines, m_level;
    bit [4:0] m_pend, m_rawq;
    int       m_held [3];
    bit       e_tick;
    bit [4:0] e_key;
    int       e_level, e_lines;

    always @(posedge clk) begin : model
        bit [4:0] raw;
        bit [4:0] req;
        int       win, per;
        bit       lr;
        raw   = {key_drop_raw, key_rotate_raw, key_down_raw, key_right_raw, key_left_raw};
        e_key = '0;
        if (rst) begin
            model_valid = 1'b1;
            m_n = 0; m_grav = 0; m_lines = 0; m_level = 0;
            m_pend = '0; m_rawq = '0;
            for (int k = 0; k < 3; k++) m_held[k] = 0;
            e_tick = 1'b0;
        end else begin
            m_n++;
            e_tick = (m_n % TDIV == TDIV - 1);
            if (game_over) begin
                m_pend = '0;
                for (int k = 0; k < 3; k++) m_held[k] = 0;
            end else begin
                if (e_tick) begin
                    for (int k = 0; k < 3; k++)
                        req[k] = m_pend[k] | (raw[k] && m_held[k] >= DAS && (m_held[k] - DAS) % ARR == 0);
                    req[3] = m_pend[3];
                    req[4] = m_pend[4];
                    win = -1; lr = 1'b0;
                    if (req[4])               win = 4;
                    else if (req[3])          win = 3;
                    else if (req[2])          win = 2;
                    else if (req[0] && req[1]) lr = 1'b1;
                    else if (req[0])          win = 0;
                    else if (req[1])          win = 1;
                    per = 30 - 2 * m_level;
                    if (per < 2) per = 2;
                    if (win == 2) m_grav = 0;
                    else begin
                        m_grav++;
                        if (win < 0 && m_grav >= per) begin
                            e_key[2] = 1'b1;
                            m_grav = 0;
                        end
                    end
                    if (win >= 0) begin
                        e_key[win]  = 1'b1;
                        m_pend[win] = 1'b0;
                    end
                    if (lr) begin
                        m_pend[0] = 1'b0;
                        m_pend[1] = 1'b0;
                    end
                    for (int k = 0; k < 3; k++) if (raw[k]) m_held[k]++;
                end
                for (int k = 0; k < 5; k++) if (raw[k] && !m_rawq[k]) m_pend[k] = 1'b1;
                for (int k = 0; k < 3; k++) if (!raw[k]) m_held[k] = 0;
            end
            m_rawq  = raw;
            m_level = (m_lines / 10 > 15) ? 15 : m_lines / 10;
            if (line_clear_valid) begin
                m_lines = m_lines + int'(line_clear_count);
                if (m_lines > 65535) m_lines = 65535;
            end
        end
        e_level = m_level;
        e_lines = m_lines;
    end

    always @(negedge clk) begin : compare
        if (model_valid) begin
            check("tick_game",   tick_game,   e_tick);
            check("key_left",    key_left,    e_key[0]);
            check("key_right",   key_right,   e_key[1]);
            check("key_down",    key_down,    e_key[2]);
            check("key_rotate",  key_rotate,  e_key[3]);
            check("key_drop",    key_drop,    e_key[4]);
            check("level",       level,       e_level);
            check("lines_total", lines_total, e_lines);
        end
    end

    // Event log: tick number of every action pulse since the last reset.
    int cyc, tick_no, first_tick;
    int q_left[$], q_right[$], q_down[$], q_rot[$], q_drop[$];

    always @(negedge clk) begin : monitor
        if (rst) begin
            cyc = 0; tick_no = 0; first_tick = 0;
        end else begin
            cyc++;
            if (tick_game) begin
                tick_no++;
                if (first_tick == 0) first_tick = cyc;
            end
            if (key_left)   q_left.push_back(tick_no);
            if (key_right)  q_right.push_back(tick_no);
            if (key_down)   q_down.push_back(tick_no);
            if (key_rotate) q_rot.push_back(tick_no);
            if (key_drop)   q_drop.push_back(tick_no);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2 * TDIV && !seen; i++) begin
            @(posedge clk);
            #2;
            if (tick_game) seen = 1'b1;
        end
        check("wait_tick", seen, 1);
    endtask

    task automatic clear_log();
        q_left.delete(); q_right.delete(); q_down.delete(); q_rot.delete(); q_drop.delete();
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic int n_actions();
        return q_left.size() + q_right.size() + q_down.size() + q_rot.size() + q_drop.size();
    endfunction

    task automatic clear_lines(input int count, input int pulses);
        for (int i = 0; i < pulses; i++) begin
            line_clear_valid = 1'b1;
            line_clear_count = 3'(count);
            step(1);
            line_clear_valid = 1'b0;
            line_clear_count = 3'd0;
            step(1);
        end
    endtask

    int t0, tb0;
    int exp_left[5] = '{1, 4, 6, 8, 10};

    initial begin
        // 1: idle timing and first gravity drop
        step(3);
        rst = 1'b0;
        clear_log();
        step(100);
        check("first_tick_cycle", first_tick, 10);
        check("ticks_in_100", tick_no, 10);
        check("idle_actions", n_actions(), 0);
        step(215);
        check("grav_count", q_down.size(), 1);
        check("grav_tick", qat(q_down, 0), 30);

        // 2: one-cycle right press issues exactly once on the next tick
        clear_log();
        wait_tick();
        step(4);
        t0 = tick_no;
        key_right_raw = 1'b1;
        step(1);
        key_right_raw = 1'b0;
        step(30);
        check("right_count", q_right.size(), 1);
        check("right_tick", qat(q_right, 0) - t0, 1);

        // 3: held left, DAS then ARR repeat
        clear_log();
        wait_tick();
        step(4);
        t0 = tick_no;
        key_left_raw = 1'b1;
        step(100);
        key_left_raw = 1'b0;
        step(20);
        check("left_count", q_left.size(), 5);
        for (int i = 0; i < 5; i++) check("left_tick", qat(q_left, i) - t0, exp_left[i]);

        // 4: drop beats rotate, rotate waits one tick; left+right cancels
        clear_log();
        wait_tick();
        step(2);
        t0 = tick_no;
        key_rotate_raw = 1'b1;
        step(1);
        key_rotate_raw = 1'b0;
        key_drop_raw = 1'b1;
        step(1);
        key_drop_raw = 1'b0;
        step(25);
        check("drop_tick", qat(q_drop, 0) - t0, 1);
        check("rotate_tick", qat(q_rot, 0) - t0, 2);
        check("drop_count", q_drop.size(), 1);
        clear_log();
        wait_tick();
        step(3);
        key_left_raw = 1'b1;
        key_right_raw = 1'b1;
        step(1);
        key_left_raw = 1'b0;
        key_right_raw = 1'b0;
        step(30);
        check("lr_left", q_left.size(), 0);
        check("lr_right", q_right.size(), 0);

        // 5: line accounting, level and gravity period
        clear_lines(0, 1);
        check("lines_zero_count", lines_total, 0);
        clear_lines(4, 3);
        step(2);
        check("lines_12", lines_total, 12);
        check("level_1", level, 1);
        clear_log();
        step(600);
        check("period_28", qat(q_down, 1) - qat(q_down, 0), 28);
        clear_lines(4, 40);
        step(2);
        check("lines_172", lines_total, 172);
        check("level_sat", level, 15);
        clear_log();
        step(100);
        check("period_2", qat(q_down, 1) - qat(q_down, 0), 2);

        // 6: game_over suppresses actions, ticks continue, no stale press
        wait_tick();
        step(3);
        key_left_raw = 1'b1;
        step(1);
        key_left_raw = 1'b0;
        step(1);
        game_over = 1'b1;
        clear_log();
        tb0 = tick_no;
        step(40);
        check("go_ticks", tick_no - tb0, 4);
        check("go_actions", n_actions(), 0);
        game_over = 1'b0;
        step(40);
        check("go_stale_left", q_left.size(), 0);

        // 7: reset in the middle of an interval with a press pending
        wait_tick();
        step(3);
        key_right_raw = 1'b1;
        step(1);
        key_right_raw = 1'b0;
        step(1);
        rst = 1'b1;
        step(1);
        check("rst_tick", tick_game, 0);
        check("rst_lines", lines_total, 0);
        check("rst_level", level, 0);
        rst = 1'b0;
        clear_log();
        step(50);
        check("rst_stale_right", q_right.size(), 0);

        // 8: lines_total saturation
        line_clear_valid = 1'b1;
        line_clear_count = 3'd4;
        step(16400);
        line_clear_valid = 1'b0;
        line_clear_count = 3'd0;
        step(2);
        check("lines_sat", lines_total, 16'hFFFF);
        check("level_at_sat", level, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
